// File: rtl/fsin_sequencer.sv
// Camera frame-sync sequencer: one period counter drives NUM_CH phase-offset FSIN pulses.
// Define FSIN_SEQUENCER_WATCHDOG_EN to compile in the frame_valid missed-frame watchdog.
module fsin_sequencer #(
  parameter int unsigned      NUM_CH     = 2,
  parameter int unsigned      CNT_W      = 24,
  parameter logic [CNT_W-1:0] DEF_PERIOD = CNT_W'(2_075_000),
  parameter logic [CNT_W-1:0] DEF_PULSE  = CNT_W'(830),
  parameter int unsigned      MISS_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    cfg_load,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [CNT_W-1:0]        cfg_pulse,
  input  logic [NUM_CH*CNT_W-1:0] cfg_phase,
  input  logic                    frame_valid,
  output logic [NUM_CH-1:0]       fsin,
  output logic                    frame_tick,
  output logic [15:0]             frame_count,
  output logic                    cfg_pending,
  output logic                    missed_frame
);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        per_q, per_d;
  logic [CNT_W-1:0]        pul_q, pul_d;
  logic [NUM_CH*CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0]        pend_per_q, pend_per_d;
  logic [CNT_W-1:0]        pend_pul_q, pend_pul_d;
  logic [NUM_CH*CNT_W-1:0] pend_phase_q, pend_phase_d;
  logic                    pending_q, pending_d;
  logic [NUM_CH-1:0]       fsin_q, fsin_d;
  logic                    tick_q, tick_d;
  logic [15:0]             count_q, count_d;
  logic [CNT_W-1:0]        last_cnt;
  logic                    wrap;
  logic                    apply;

  // Period counter; periods below 2 are stretched to 2 so the counter always moves.
  always_comb begin : counter_next
    last_cnt = (per_q < CNT_W'(2)) ? CNT_W'(1) : per_q - CNT_W'(1);
    wrap     = enable && (cnt_q >= last_cnt);
    cnt_d    = '0;
    if (enable && !wrap) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tick_d  = enable && (cnt_q == '0);
    count_d = tick_d ? count_q + 16'd1 : count_q;
  end

  // Pulse window is clipped at the period end so it never spills into the next frame.
  always_comb begin : window_next
    logic [CNT_W-1:0] ph;
    logic [CNT_W:0]   win_end;
    fsin_d  = '0;
    ph      = '0;
    win_end = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ph      = phase_q[i*CNT_W +: CNT_W];
      win_end = {1'b0, ph} + {1'b0, pul_q};
      if (win_end > {1'b0, per_q}) begin
        win_end = {1'b0, per_q};
      end
      fsin_d[i] = enable && (pul_q != '0) && (ph < per_q) &&
                  (cnt_q >= ph) && ({1'b0, cnt_q} < win_end);
    end
  end

  // Pending config lands on the wrap edge, or immediately when stopped.
  always_comb begin : config_next
    apply        = pending_q && (wrap || !enable);
    per_d        = apply ? pend_per_q   : per_q;
    pul_d        = apply ? pend_pul_q   : pul_q;
    phase_d      = apply ? pend_phase_q : phase_q;
    pend_per_d   = cfg_load ? cfg_period : pend_per_q;
    pend_pul_d   = cfg_load ? cfg_pulse  : pend_pul_q;
    pend_phase_d = cfg_load ? cfg_phase  : pend_phase_q;
    pending_d    = cfg_load || (pending_q && !apply);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      per_q        <= DEF_PERIOD;
      pul_q        <= DEF_PULSE;
      phase_q      <= '0;
      pend_per_q   <= '0;
      pend_pul_q   <= '0;
      pend_phase_q <= '0;
      pending_q    <= 1'b0;
      fsin_q       <= '0;
      tick_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      cnt_q        <= cnt_d;
      per_q        <= per_d;
      pul_q        <= pul_d;
      phase_q      <= phase_d;
      pend_per_q   <= pend_per_d;
      pend_pul_q   <= pend_pul_d;
      pend_phase_q <= pend_phase_d;
      pending_q    <= pending_d;
      fsin_q       <= fsin_d;
      tick_q       <= tick_d;
      count_q      <= count_d;
    end
  end

  assign fsin        = fsin_q;
  assign frame_tick  = tick_q;
  assign frame_count = count_q;
  assign cfg_pending = pending_q;

`ifdef FSIN_SEQUENCER_WATCHDOG_EN
  localparam int unsigned MISS_W = (MISS_LIMIT < 1) ? 1 : $clog2(MISS_LIMIT + 1);
  localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(MISS_LIMIT);

  logic              fv_meta_q, fv_sync_q, fv_prev_q;
  logic              fv_rise;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              missed_q, missed_d;

  // Miss counter saturates; the flag is sticky until reset or stop.
  always_comb begin : watchdog_next
    fv_rise = fv_sync_q && !fv_prev_q;
    miss_d  = miss_q;
    if (!enable || fv_rise) begin
      miss_d = '0;
    end else if (tick_q && (miss_q < MISS_MAX)) begin
      miss_d = miss_q + MISS_W'(1);
    end
    missed_d = enable && (missed_q || (miss_d >= MISS_MAX));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fv_meta_q <= 1'b0;
      fv_sync_q <= 1'b0;
      fv_prev_q <= 1'b0;
      miss_q    <= '0;
      missed_q  <= 1'b0;
    end else begin
      fv_meta_q <= frame_valid;
      fv_sync_q <= fv_meta_q;
      fv_prev_q <= fv_sync_q;
      miss_q    <= miss_d;
      missed_q  <= missed_d;
    end
  end

  assign missed_frame = missed_q;
`else
  logic unused_fv;
  assign unused_fv    = frame_valid;
  assign missed_frame = 1'b0;
`endif

endmodule

// File: doc/fsin_sequencer.md
FSIN_SEQUENCER -- requirements
Module: fsin_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, giving the number of camera frame-sync channels.
REQ-002 The block SHALL have parameter CNT_W, default 24, giving the width of the period, pulse and phase values.
REQ-003 The block SHALL have parameter DEF_PERIOD, default 24'd2_075_000 (40 Hz at 83 MHz), giving the period after reset.
REQ-004 The block SHALL have parameter DEF_PULSE, default 24'd830, giving the pulse length after reset.
REQ-005 The block SHALL have parameter MISS_LIMIT, default 4, giving the watchdog threshold in frames.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port enable, input, 1 bit: run/stop.
REQ-009 The block SHALL have port cfg_load, input, 1 bit: one-cycle strobe that captures cfg_period, cfg_pulse and cfg_phase.
REQ-010 The block SHALL have port cfg_period, input, CNT_W bits: frame period in clk cycles.
REQ-011 The block SHALL have port cfg_pulse, input, CNT_W bits: FSIN high time in clk cycles.
REQ-012 The block SHALL have port cfg_phase, input, NUM_CH*CNT_W bits: per-channel offset, with channel i in slice [i*CNT_W +: CNT_W].
REQ-013 The block SHALL have port frame_valid, input, 1 bit: camera FV, asynchronous to clk.
REQ-014 The block SHALL have port fsin, output, NUM_CH bits: frame-sync pulses.
REQ-015 The block SHALL have port frame_tick, output, 1 bit: one-cycle strobe at period start.
REQ-016 The block SHALL have port frame_count, output, 16 bits: count of period starts.
REQ-017 The block SHALL have port cfg_pending, output, 1 bit: high while a loaded configuration awaits application.
REQ-018 The block SHALL have port missed_frame, output, 1 bit: sticky watchdog flag.

Function
REQ-019 Counter cnt SHALL count 0..per_q-1 while enable=1 and wrap to 0; effective period SHALL be max(per_q,2).
REQ-020 While enable=0, cnt SHALL be held at 0, fsin SHALL be 0 and frame_tick SHALL be 0; counting SHALL resume from cnt=0 on the first cycle after enable returns to 1.
REQ-021 fsin[i] SHALL be registered, one cycle behind cnt, and high iff phase_i <= cnt < min(phase_i+pul_q, per_q); a pulse SHALL never wrap into the next period.
REQ-022 If phase_i >= per_q or pul_q=0, fsin[i] SHALL stay low.
REQ-023 The phase_i+pul_q sum SHALL be computed at CNT_W+1 bits so that no overflow occurs.
REQ-024 frame_tick SHALL pulse for one cycle, registered, for each cycle in which cnt=0 while enabled; frame_count SHALL increment on each frame_tick and wrap 0xFFFF->0.
REQ-025 cfg_load SHALL copy the inputs into pending registers and set cfg_pending.
REQ-026 Pending values SHALL transfer to per_q/pul_q/phase_q on the next wrap of cnt to 0, or on the next cycle if enable=0; cfg_pending SHALL then clear.
REQ-027 A cfg_load coinciding with the wrap cycle SHALL be captured and applied at the following wrap; a second cfg_load before application SHALL overwrite the pending values.
REQ-028 frame_valid SHALL be synchronised by two flops, and its rising edge SHALL be detected on the synchronised signal.

Reset
REQ-029 On reset: cnt=0, fsin=0, frame_tick=0, frame_count=0, cfg_pending=0, missed_frame=0, synchroniser flops=0, per_q=DEF_PERIOD, pul_q=DEF_PULSE, all phase_q=0.
REQ-030 Reset asserted mid-pulse SHALL drop fsin asynchronously, and a pending configuration SHALL be discarded.

Configuration
REQ-031 Macro FSIN_SEQUENCER_WATCHDOG_EN SHALL compile in a miss counter that clears on a synchronised FV rising edge and increments on each frame_tick.
REQ-032 With the macro defined, missed_frame SHALL set when the miss counter reaches MISS_LIMIT and SHALL stay set until reset or enable=0.
REQ-033 Without the macro, missed_frame SHALL be constant 0 and the synchroniser and counter logic SHALL be absent.

Verification
REQ-034 The bench SHALL check: per=10, pulse=3, phase={0,4}, enable=1 -> fsin[0] high on cnt 0-2, fsin[1] high on cnt 4-6, period 10 clk, frame_tick every 10 clk.
REQ-035 The bench SHALL check: per=10, pulse=5, phase[1]=8 -> fsin[1] high for 2 cycles only; phase[1]=12 -> fsin[1] never high.
REQ-036 The bench SHALL check: cfg_load per=20 at cnt=3 -> cfg_pending=1 until wrap, the current period completes at 10, and the next period is 20; cfg_load on the wrap cycle -> applied one period later.
REQ-037 The bench SHALL check: enable dropped at cnt=1 with pulse=3 -> fsin=0 the next cycle; re-enable -> cnt restarts at 0 and frame_count continues incrementing.
REQ-038 The bench SHALL check, with the macro and MISS_LIMIT=4: no FV edges for 4 ticks -> missed_frame=1 after the 4th tick; an FV edge every period -> missed_frame stays 0.
REQ-039 The bench SHALL check: reset asserted mid-pulse -> all outputs go to their reset values without waiting for a clock edge, and per_q reverts to DEF_PERIOD.
